seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//   Time-multiplexed N-digit 7-segment driver; successor to the single-digit BCD decoder.
//   Double-buffers a packed hex/BCD word, scans one digit per refresh slot with anti-ghost
//   guard time, optional leading-zero blanking and polarity select. Sits between the
//   datapath and the board's shared segment bus plus per-digit anode enables.
// PARAMETERS
//   N_DIGITS    4     digits driven, 1..8; digit 0 = least significant nibble
//   REFRESH_DIV 1000  clk cycles per digit slot, >= GUARD+2
//   GUARD       2     cycles at slot start with all anodes inactive, >= 1
//   HEX_EN      1     1: nibbles 10..15 show A,b,C,d,E,F; 0: they show blank
//   ACTIVE_LOW  0     1: seg, seg_dp and an are all inverted at the pins
// PORTS
//   clk        in   1           system clock, rising edge
//   rst_n      in   1           asynchronous active-low reset
//   load       in   1           capture value/dp_in into pending buffer this cycle
//   value      in   4*N_DIGITS  nibble k = digit k
//   dp_in      in   N_DIGITS    decimal point per digit, captured with value
//   blank_lz   in   1           leading-zero blanking enable, sampled live
//   seg        out  7           {g,f,e,d,c,b,a}, seg[0]=a
//   seg_dp     out  1           decimal point of current digit
//   an         out  N_DIGITS    one-hot digit enable, an[k] lights digit k
//   frame_done out  1           1-cycle pulse when scan wraps digit N_DIGITS-1 -> 0
// BEHAVIOUR
//   Reset: prescaler=0, idx=0, pending=active=0, dp=0, frame_done=0; an and seg/seg_dp
//     inactive (0 if ACTIVE_LOW=0, all-ones if 1). Reset mid-scan aborts slot immediately.
//   Prescaler counts 0..REFRESH_DIV-1; at terminal count idx advances, N_DIGITS-1 wraps to 0.
//   Frame boundary = cycle prescaler hits terminal count with idx=N_DIGITS-1; frame_done
//     registered, high the cycle after that boundary, exactly once per frame.
//   Buffering: load writes pending (latest load wins). At frame boundary active<=pending;
//     if load is high in the boundary cycle, value/dp_in go straight into active and pending.
//     Display never changes mid-frame (no tearing).
//   Outputs registered, 1-cycle latency from prescaler/idx: an[idx] active while prescaler in
//     GUARD..REFRESH_DIV-1, all anodes inactive while prescaler < GUARD; seg/seg_dp show
//     digit idx throughout the slot (incl. guard).
//   Decode (active-high): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F
//     A=77 b=7C C=39 d=5E E=79 F=71; blank=00. HEX_EN=0: 10..15 -> blank.
//   Leading-zero blanking (blank_lz=1): digit k blanked (seg=00, dp still shown) if nibbles
//     k..N_DIGITS-1 of active are all zero and k>0; digit 0 never blanked.
//   Blanked digit still gets its slot and anode (uniform brightness timing).
//   ACTIVE_LOW inverts only the final output registers; internal logic identical.
// TESTING  (bench: N_DIGITS=4, REFRESH_DIV=8, GUARD=2 unless stated)
//   Reset held then released -> an=0000, seg=00, frame_done=0; first an=0001 at cycle 3.
//   load value=16'h1234 then wait frame_done -> slots show 66,4F,5B,06 with an
//     0001,0010,0100,1000; an=0000 for 2 cycles at each slot start; frame_done every 32 cycles.
//   blank_lz=1, value=16'h0070 -> digit0=3F, digit1=07, digits 2,3 seg=00;
//     value=16'h0000 -> only digit0 shows 3F.
//   load 16'hABCD mid-frame -> remainder of frame keeps old digits; next frame 5E,39,7C,77.
//   load in boundary cycle -> new value shown from very next frame; HEX_EN=0 with F -> 00.
//   ACTIVE_LOW=1, value 8 dp_in[0]=1 -> digit0 seg=00, seg_dp=0, an=1110; rst_n low
//     mid-slot -> outputs all-ones immediately, asynchronously.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//   Time-multiplexed N-digit 7-segment display driver.
//   A packed hex/BCD word is written into a pending buffer. It moves into the
//   active buffer only at a frame boundary, so a frame on the glass never mixes
//   old and new digits. One digit is scanned per refresh slot. Each slot opens
//   with a guard window in which every anode is off, so the previous digit's
//   segments do not ghost onto the next digit. Optional leading-zero blanking
//   and a pin polarity select are provided.
//
// Parameters
//   N_DIGITS    digits driven (1..8), digit 0 = least significant nibble
//   REFRESH_DIV clk cycles per digit slot (>= GUARD+2)
//   GUARD       cycles at the start of each slot with all anodes off (>= 1)
//   HEX_EN      1: nibbles 10..15 show A,b,C,d,E,F; 0: they show blank
//   ACTIVE_LOW  1: seg, seg_dp and an are inverted at the pins
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   load       in   capture value/dp_in into the pending buffer this cycle
//   value      in   packed nibbles, nibble k = digit k
//   dp_in      in   decimal point per digit, captured together with value
//   blank_lz   in   leading-zero blanking enable, sampled live
//   seg        out  {g,f,e,d,c,b,a}, seg[0] = a
//   seg_dp     out  decimal point of the digit being scanned
//   an         out  one-hot digit enable, an[k] lights digit k
//   frame_done out  1-cycle pulse after the scan wraps digit N_DIGITS-1 -> 0
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
   parameter int N_DIGITS    = 4,
   parameter int REFRESH_DIV = 1000,
   parameter int GUARD       = 2,
   parameter int HEX_EN      = 1,
   parameter int ACTIVE_LOW  = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [4*N_DIGITS-1:0]   value,
   input  logic [N_DIGITS-1:0]     dp_in,
   input  logic                    blank_lz,
   output logic [6:0]              seg,
   output logic                    seg_dp,
   output logic [N_DIGITS-1:0]     an,
   output logic                    frame_done
);

   // --------------------------------------------------------------------------
   // Derived constants
   // --------------------------------------------------------------------------
   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [PW-1:0] GUARD_END  = PW'(GUARD);
   localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

   // Pin polarity: the internal datapath is always active-high and the
   // inversion is applied only when loading the output registers.
   localparam logic POL = (ACTIVE_LOW != 0);
   localparam logic SHOW_HEX = (HEX_EN != 0);

   localparam logic [6:0]          SEG_OFF = {7{POL}};
   localparam logic [N_DIGITS-1:0] AN_OFF  = {N_DIGITS{POL}};

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   logic [PW-1:0]           prescaler_reg;
   logic [IW-1:0]           idx_reg;
   logic [4*N_DIGITS-1:0]   pending_value_reg;
   logic [N_DIGITS-1:0]     pending_dp_reg;
   logic [4*N_DIGITS-1:0]   active_value_reg;
   logic [N_DIGITS-1:0]     active_dp_reg;

   // --------------------------------------------------------------------------
   // Scan timing
   // --------------------------------------------------------------------------
   logic slot_end;
   logic frame_end;

   assign slot_end  = (prescaler_reg == PRESC_LAST);
   assign frame_end = slot_end && (idx_reg == IDX_LAST);

   // --------------------------------------------------------------------------
   // Per-digit views of the active buffer
   // --------------------------------------------------------------------------
   logic [3:0]          nibble [N_DIGITS];
   // upper_zero[k]: nibbles k..N_DIGITS-1 of the active word are all zero
   logic [N_DIGITS-1:0] upper_zero;

   genvar gi;
   generate
      for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
         assign nibble[gi]     = active_value_reg[4*gi +: 4];
         assign upper_zero[gi] = ~|active_value_reg[4*N_DIGITS-1:4*gi];
      end
   endgenerate

   // --------------------------------------------------------------------------
   // Segment decode, active-high {g,f,e,d,c,b,a}
   // --------------------------------------------------------------------------
   function automatic logic [6:0] decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0:    s = 7'h3F;
         4'h1:    s = 7'h06;
         4'h2:    s = 7'h5B;
         4'h3:    s = 7'h4F;
         4'h4:    s = 7'h66;
         4'h5:    s = 7'h6D;
         4'h6:    s = 7'h7D;
         4'h7:    s = 7'h07;
         4'h8:    s = 7'h7F;
         4'h9:    s = 7'h6F;
         4'hA:    s = SHOW_HEX ? 7'h77 : 7'h00;
         4'hB:    s = SHOW_HEX ? 7'h7C : 7'h00;
         4'hC:    s = SHOW_HEX ? 7'h39 : 7'h00;
         4'hD:    s = SHOW_HEX ? 7'h5E : 7'h00;
         4'hE:    s = SHOW_HEX ? 7'h79 : 7'h00;
         default: s = SHOW_HEX ? 7'h71 : 7'h00;
      endcase
      return s;
   endfunction

   // --------------------------------------------------------------------------
   // Next output values, computed from the current prescaler/idx so that the
   // pins follow the scan state with exactly one cycle of latency.
   // --------------------------------------------------------------------------
   logic [3:0]          cur_nibble;
   logic                cur_blank;
   logic [6:0]          seg_next;
   logic                seg_dp_next;
   logic [N_DIGITS-1:0] an_next;
   logic [N_DIGITS-1:0] an_onehot;

   assign an_onehot = {{(N_DIGITS-1){1'b0}}, 1'b1} << idx_reg;

   always_comb begin
      cur_nibble  = nibble[idx_reg];
      // Digit 0 is never blanked so an all-zero word still shows a single 0.
      cur_blank   = blank_lz && (idx_reg != '0) && upper_zero[idx_reg];
      seg_next    = cur_blank ? 7'h00 : decode(cur_nibble);
      // The decimal point survives leading-zero blanking.
      seg_dp_next = active_dp_reg[idx_reg];
      // Segments already carry the new digit during the guard window; only
      // the anodes are held off to keep the previous digit from ghosting.
      an_next     = (prescaler_reg >= GUARD_END) ? an_onehot : '0;
   end

   // --------------------------------------------------------------------------
   // Prescaler and digit index
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler_reg <= '0;
         idx_reg       <= '0;
      end else if (slot_end) begin
         prescaler_reg <= '0;
         idx_reg       <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
      end else begin
         prescaler_reg <= prescaler_reg + PW'(1);
      end
   end

   // --------------------------------------------------------------------------
   // Double buffer. A load in the boundary cycle bypasses pending and lands in
   // active directly, so the very next frame already shows it.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_value_reg <= '0;
         pending_dp_reg    <= '0;
         active_value_reg  <= '0;
         active_dp_reg     <= '0;
      end else begin
         if (load) begin
            pending_value_reg <= value;
            pending_dp_reg    <= dp_in;
         end
         if (frame_end) begin
            active_value_reg <= load ? value : pending_value_reg;
            active_dp_reg    <= load ? dp_in : pending_dp_reg;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Output registers (polarity applied here only)
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg        <= SEG_OFF;
         seg_dp     <= POL;
         an         <= AN_OFF;
         frame_done <= 1'b0;
      end else begin
         seg        <= seg_next ^ SEG_OFF;
         seg_dp     <= seg_dp_next ^ POL;
         an         <= an_next ^ AN_OFF;
         frame_done <= frame_end;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//   Directed bench for seg7_scan_driver with N_DIGITS=4, REFRESH_DIV=8,
//   GUARD=2. Three instances share the stimulus: the default configuration,
//   one with HEX_EN=0 and one with ACTIVE_LOW=1.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic        blank_lz;

   logic [6:0]  seg_m, seg_h, seg_a;
   logic        dp_m, dp_h, dp_a;
   logic [3:0]  an_m, an_h, an_a;
   logic        fd_m, fd_h, fd_a;

   int tests  = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seg7_scan_driver #(
      .N_DIGITS(4), .REFRESH_DIV(8), .GUARD(2), .HEX_EN(1), .ACTIVE_LOW(0)
   ) dut_main (
      .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
      .blank_lz(blank_lz), .seg(seg_m), .seg_dp(dp_m), .an(an_m),
      .frame_done(fd_m)
   );

   seg7_scan_driver #(
      .N_DIGITS(4), .REFRESH_DIV(8), .GUARD(2), .HEX_EN(0), .ACTIVE_LOW(0)
   ) dut_hex0 (
      .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
      .blank_lz(blank_lz), .seg(seg_h), .seg_dp(dp_h), .an(an_h),
      .frame_done(fd_h)
   );

   seg7_scan_driver #(
      .N_DIGITS(4), .REFRESH_DIV(8), .GUARD(2), .HEX_EN(1), .ACTIVE_LOW(1)
   ) dut_al (
      .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
      .blank_lz(blank_lz), .seg(seg_a), .seg_dp(dp_a), .an(an_a),
      .frame_done(fd_a)
   );

   task automatic check(input string tag, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // One clock, then settle 1 time unit past the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input logic [15:0] v, input logic [3:0] d);
      value = v;
      dp_in = d;
      load  = 1'b1;
      tick();
      load  = 1'b0;
   endtask

   // Returns just after the edge on which frame_done goes high.
   task automatic wait_fd();
      bit seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         tick();
         if (fd_m) seen = 1'b1;
      end
      if (!seen) check("frame_done_timeout", 32'd0, 32'd1);
   endtask

   // Called just after frame_done rose. Checks the 32 cycles of one frame:
   // slot s occupies cycles 8s+1..8s+8, anodes off for the first two.
   task automatic check_frame(input logic [3:0][6:0] exp_seg,
                              input logic [3:0] exp_dp);
      for (int j = 1; j <= 32; j++) begin
         int s, p;
         logic [3:0] exp_an;
         tick();
         s = (j - 1) / 8;
         p = (j - 1) % 8;
         exp_an = (p < 2) ? 4'b0000 : (4'b0001 << s);
         check("an", 32'(an_m), 32'(exp_an));
         check("seg", 32'(seg_m), 32'(exp_seg[s]));
         check("seg_dp", 32'(dp_m), 32'(exp_dp[s]));
         check("frame_done", 32'(fd_m), 32'(j == 32));
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      load     = 1'b0;
      value    = 16'h0000;
      dp_in    = 4'b0000;
      blank_lz = 1'b0;

      // Reset state
      tick(); tick(); tick();
      check("rst_an", 32'(an_m), 32'h0);
      check("rst_seg", 32'(seg_m), 32'h00);
      check("rst_dp", 32'(dp_m), 32'h0);
      check("rst_fd", 32'(fd_m), 32'h0);
      check("rst_fd_h", 32'(fd_h), 32'h0);
      check("rst_fd_a", 32'(fd_a), 32'h0);
      check("rst_al_an", 32'(an_a), 32'hF);
      check("rst_al_seg", 32'(seg_a), 32'h7F);
      check("rst_al_dp", 32'(dp_a), 32'h1);

      // First anode appears on the third edge after release
      rst_n = 1'b1;
      tick();
      check("an_cyc1", 32'(an_m), 32'h0);
      tick();
      check("an_cyc2", 32'(an_m), 32'h0);
      tick();
      check("an_cyc3", 32'(an_m), 32'h1);
      check("seg_cyc3", 32'(seg_m), 32'h3F);

      // 1234: digit0..3 = 66,4F,5B,06, two full frames
      load_word(16'h1234, 4'b0000);
      wait_fd();
      check_frame({7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0000);
      check_frame({7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0000);

      // Mid-frame load: current frame untouched, next frame shows ABCD
      fork
         begin
            repeat (10) tick();
            load_word(16'hABCD, 4'b0000);
         end
         check_frame({7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0000);
      join
      // Load in the boundary cycle (8th cycle of slot 3) of the ABCD frame
      fork
         begin
            repeat (31) tick();
            load_word(16'h0070, 4'b0000);
         end
         check_frame({7'h77, 7'h7C, 7'h39, 7'h5E}, 4'b0000);
      join

      // Leading-zero blanking on 0070
      blank_lz = 1'b1;
      fork
         begin
            repeat (5) tick();
            load_word(16'h0000, 4'b0100);
         end
         check_frame({7'h00, 7'h00, 7'h07, 7'h3F}, 4'b0000);
      join
      // 0000: only digit0 lit; blanked digit2 keeps its decimal point
      fork
         begin
            repeat (5) tick();
            load_word(16'hF008, 4'b0001);
         end
         check_frame({7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0100);
      join

      // F008 with dp0: HEX_EN=0 blanks the F, ACTIVE_LOW inverts pins
      fork
         begin
            repeat (3) tick();
            check("al_an", 32'(an_a), 32'hE);
            check("al_seg", 32'(seg_a), 32'h00);
            check("al_dp", 32'(dp_a), 32'h0);
            check("hex0_seg_d0", 32'(seg_h), 32'h7F);
            check("hex0_dp_d0", 32'(dp_h), 32'h1);
            repeat (24) tick();
            check("hex0_seg_F", 32'(seg_h), 32'h00);
            check("hex0_an_d3", 32'(an_h), 32'h8);
            check("al_seg_F", 32'(seg_a), 32'h0E);
         end
         check_frame({7'h71, 7'h3F, 7'h3F, 7'h7F}, 4'b0001);
      join

      // Asynchronous reset mid-slot, sampled before any further edge
      repeat (4) tick();
      check("pre_rst_al_an", 32'(an_a), 32'hE);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_al_an", 32'(an_a), 32'hF);
      check("arst_al_seg", 32'(seg_a), 32'h7F);
      check("arst_al_dp", 32'(dp_a), 32'h1);
      check("arst_an", 32'(an_m), 32'h0);
      check("arst_seg", 32'(seg_m), 32'h00);
      check("arst_fd", 32'(fd_m), 32'h0);
      tick();
      rst_n = 1'b1;

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
